// File: rtl/approx_add_error_monitor.sv
// approx_add_error_monitor
//
// Consumes result samples from an approximate adder under test and
// accumulates error statistics over a programmed number of samples. It
// computes the exact sum internally. It reports the error count, the sum of
// absolute errors, the sum of squared errors and the largest absolute error.
// The results are then held until the next run is started.
//
// Parameters
//   WIDTH  operand width; the approximate sum is WIDTH+1 bits
//   CNT_W  width of the sample counter and num_samples
//   ACC_W  width of the sum_abs_err / sum_sq_err accumulators
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        begin a run (only honoured in IDLE or DONE)
//   num_samples  samples per run, captured when start is accepted
//   in_valid     sample present on in_a / in_b / in_approx
//   in_ready     sample accepted this cycle when in_valid is also high
//   in_a, in_b   operands presented to the adder under test
//   in_approx    approximate sum produced by the adder under test
//   busy         run in progress (RUN or DRAIN)
//   done         results valid, held until the next accepted start
//   err_count    samples whose error was nonzero
//   sum_abs_err  sum of |exact - approx|, clamps at all-ones
//   sum_sq_err   sum of (exact - approx)^2, clamps at all-ones
//   max_abs_err  largest |exact - approx| seen this run
//   saturated    sticky: an accumulator clamped during this run
module approx_add_error_monitor #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned ACC_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [WIDTH:0]     in_approx,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   err_count,
  output logic [ACC_W-1:0]   sum_abs_err,
  output logic [ACC_W-1:0]   sum_sq_err,
  output logic [WIDTH:0]     max_abs_err,
  output logic               saturated
);

  localparam int unsigned SW     = WIDTH + 1;
  localparam int unsigned PW     = 2 * WIDTH + 2;
  // Accumulator adds are done one bit wider than the wider operand, so the
  // carry shows whether the true sum exceeds the ACC_W range.
  localparam int unsigned AW_ABS = ((ACC_W > SW) ? ACC_W : SW) + 1;
  localparam int unsigned AW_SQ  = ((ACC_W > PW) ? ACC_W : PW) + 1;

  localparam logic [AW_ABS-1:0] ABS_MAX = {{(AW_ABS-ACC_W){1'b0}}, {ACC_W{1'b1}}};
  localparam logic [AW_SQ-1:0]  SQ_MAX  = {{(AW_SQ-ACC_W){1'b0}}, {ACC_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] accepted;
  logic             start_ok;
  logic             transfer;
  logic             last_xfer;

  // Stage 1 registers
  logic             s1_valid;
  logic [SW-1:0]    s1_abs;
  logic             s1_nz;

  // Stage 1 combinational datapath
  logic [SW-1:0]    exact_c;
  logic [SW-1:0]    abs_c;

  // Stage 2 combinational datapath
  logic [AW_ABS-1:0] abs_sum;
  logic [PW-1:0]     sq_prod;
  logic [AW_SQ-1:0]  sq_sum;
  logic              abs_ovf;
  logic              sq_ovf;

  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign transfer  = in_valid && in_ready;
  assign last_xfer = transfer && (accepted == (target - CNT_W'(1)));

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          state_nxt = (num_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy     = 1'b1;
        in_ready = (accepted < target);
        if (last_xfer) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // The final sample sits in stage 1 here and reaches stage 2 on this
        // edge, so DONE coincides with its update becoming visible.
        busy      = 1'b1;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Sample counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target   <= '0;
      accepted <= '0;
    end else if (start_ok) begin
      target   <= num_samples;
      accepted <= '0;
    end else if (transfer) begin
      accepted <= accepted + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: exact sum and absolute error
  // ---------------------------------------------------------------------
  always_comb begin
    exact_c = {1'b0, in_a} + {1'b0, in_b};
    abs_c   = (exact_c >= in_approx) ? (exact_c - in_approx)
                                     : (in_approx - exact_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_abs   <= '0;
      s1_nz    <= 1'b0;
    end else begin
      s1_valid <= transfer;
      if (transfer) begin
        s1_abs <= abs_c;
        s1_nz  <= (abs_c != '0);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: statistic accumulation with saturation
  // ---------------------------------------------------------------------
  always_comb begin
    abs_sum = {{(AW_ABS-ACC_W){1'b0}}, sum_abs_err} + {{(AW_ABS-SW){1'b0}}, s1_abs};
    sq_prod = {{(PW-SW){1'b0}}, s1_abs} * {{(PW-SW){1'b0}}, s1_abs};
    sq_sum  = {{(AW_SQ-ACC_W){1'b0}}, sum_sq_err} + {{(AW_SQ-PW){1'b0}}, sq_prod};
    abs_ovf = (abs_sum > ABS_MAX);
    sq_ovf  = (sq_sum > SQ_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count   <= '0;
      sum_abs_err <= '0;
      sum_sq_err  <= '0;
      max_abs_err <= '0;
      saturated   <= 1'b0;
    end else if (start_ok) begin
      err_count   <= '0;
      sum_abs_err <= '0;
      sum_sq_err  <= '0;
      max_abs_err <= '0;
      saturated   <= 1'b0;
    end else if (s1_valid) begin
      err_count   <= err_count + CNT_W'(s1_nz);
      sum_abs_err <= abs_ovf ? '1 : abs_sum[ACC_W-1:0];
      sum_sq_err  <= sq_ovf  ? '1 : sq_sum[ACC_W-1:0];
      if (s1_abs > max_abs_err) begin
        max_abs_err <= s1_abs;
      end
      if (abs_ovf || sq_ovf) begin
        saturated <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_approx_add_error_monitor.sv
module tb_approx_add_error_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] num_samples = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [16:0] in_approx = '0;

  logic        in_ready, busy, done, saturated;
  logic [31:0] err_count;
  logic [63:0] sum_abs_err, sum_sq_err;
  logic [16:0] max_abs_err;

  logic        in_ready8, busy8, done8, sat8;
  logic [31:0] err8;
  logic [7:0]  abs8, sq8;
  logic [16:0] max8;

  int passes = 0;
  int total  = 0;

  approx_add_error_monitor #(.WIDTH(16), .CNT_W(32), .ACC_W(64)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_approx(in_approx), .busy(busy), .done(done), .err_count(err_count),
    .sum_abs_err(sum_abs_err), .sum_sq_err(sum_sq_err),
    .max_abs_err(max_abs_err), .saturated(saturated)
  );

  approx_add_error_monitor #(.WIDTH(16), .CNT_W(32), .ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready8), .in_a(in_a), .in_b(in_b),
    .in_approx(in_approx), .busy(busy8), .done(done8), .err_count(err8),
    .sum_abs_err(abs8), .sum_sq_err(sq8),
    .max_abs_err(max8), .saturated(sat8)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic start_run(input logic [31:0] n);
    start       = 1'b1;
    num_samples = n;
    tick();
    start       = 1'b0;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [16:0] ap);
    bit ok;
    ok        = 1'b0;
    in_a      = a;
    in_b      = b;
    in_approx = ap;
    in_valid  = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("push_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check(tag, 64'(done), 64'd1);
  endtask

  logic [63:0] ex, ae;
  logic [63:0] m_err, m_abs, m_sq, m_max;
  int          xfers, cyc;
  bit          pending;

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_sum_abs", sum_abs_err, 64'd0);
    check("rst_sum_sq", sum_sq_err, 64'd0);
    check("rst_max", 64'(max_abs_err), 64'd0);
    check("rst_saturated", 64'(saturated), 64'd0);
    rst = 1'b0;
    tick();

    // Reset in the middle of a run
    start_run(32'd10);
    check("mid_busy", 64'(busy), 64'd1);
    push(16'd1, 16'd1, 17'd3);
    push(16'd1, 16'd1, 17'd3);
    push(16'd1, 16'd1, 17'd3);
    tick();
    check("mid_err_before_rst", 64'(err_count), 64'd3);
    check("mid_ready_before_rst", 64'(in_ready), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_err", 64'(err_count), 64'd0);
    check("mid_rst_sum_abs", sum_abs_err, 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Exact samples, back-to-back valid: one transfer per cycle
    start_run(32'd4);
    check("exact_busy", 64'(busy), 64'd1);
    check("exact_done_low", 64'(done), 64'd0);
    in_a      = 16'h1234;
    in_b      = 16'h1234;
    in_approx = 17'h02468;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("b2b_ready", 64'(in_ready), 64'd1);
      tick();
    end
    check("exact_ready_after_last", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    check("exact_drain_busy", 64'(busy), 64'd1);
    check("exact_drain_done", 64'(done), 64'd0);
    tick();
    check("exact_done", 64'(done), 64'd1);
    check("exact_busy_low", 64'(busy), 64'd0);
    check("exact_err", 64'(err_count), 64'd0);
    check("exact_sum_abs", sum_abs_err, 64'd0);
    check("exact_sum_sq", sum_sq_err, 64'd0);
    check("exact_max", 64'(max_abs_err), 64'd0);

    // Mixed errors: 1, 1, 0
    start_run(32'd3);
    check("mixed_done_drops", 64'(done), 64'd0);
    push(16'd1, 16'd1, 17'd3);
    push(16'hFFFF, 16'd1, 17'h0FFFF);
    push(16'd5, 16'd2, 17'd7);
    wait_done("mixed_done");
    check("mixed_err", 64'(err_count), 64'd2);
    check("mixed_sum_abs", sum_abs_err, 64'd2);
    check("mixed_sum_sq", sum_sq_err, 64'd2);
    check("mixed_max", 64'(max_abs_err), 64'd1);

    // Largest possible error
    start_run(32'd1);
    push(16'hFFFF, 16'hFFFF, 17'd0);
    check("large_done_latency", 64'(done), 64'd0);
    tick();
    check("large_done", 64'(done), 64'd1);
    check("large_err", 64'(err_count), 64'd1);
    check("large_sum_abs", sum_abs_err, 64'h1FFFE);
    check("large_sum_sq", sum_sq_err, 64'h3FFF80004);
    check("large_max", 64'(max_abs_err), 64'h1FFFE);

    // DONE holds outputs while unrelated traffic arrives
    in_a = 16'd1;
    in_b = 16'd1;
    in_approx = 17'd0;
    in_valid = 1'b1;
    tick();
    tick();
    tick();
    check("hold_ready", 64'(in_ready), 64'd0);
    check("hold_done", 64'(done), 64'd1);
    check("hold_err", 64'(err_count), 64'd1);
    check("hold_sum_abs", sum_abs_err, 64'h1FFFE);
    in_valid = 1'b0;

    // Random backpressure over 100 samples against a reference model
    m_err = '0; m_abs = '0; m_sq = '0; m_max = '0;
    xfers = 0; cyc = 0; pending = 1'b0; ex = '0;
    start_run(32'd100);
    while (xfers < 100 && cyc < 2000) begin
      if (!pending) begin
        in_a = 16'($urandom);
        in_b = 16'($urandom);
        ex   = 64'(in_a) + 64'(in_b);
        case ($urandom_range(0, 3))
          0: in_approx = 17'(ex);
          1: in_approx = 17'(ex + 64'($urandom_range(0, 15)));
          2: in_approx = 17'($urandom);
          default: in_approx = 17'(ex) ^ 17'h00100;
        endcase
        pending = 1'b1;
      end
      in_valid = ($urandom_range(0, 1) == 1);
      if (in_valid && in_ready) begin
        ae = (ex >= 64'(in_approx)) ? (ex - 64'(in_approx)) : (64'(in_approx) - ex);
        m_err += 64'(ae != 0);
        m_abs += ae;
        m_sq  += ae * ae;
        if (ae > m_max) m_max = ae;
        xfers++;
        pending = 1'b0;
      end
      tick();
      cyc++;
    end
    check("rand_transfers", 64'(xfers), 64'd100);
    in_valid = 1'b1;
    check("rand_ready_after_100", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    wait_done("rand_done");
    check("rand_err", 64'(err_count), m_err);
    check("rand_sum_abs", sum_abs_err, m_abs);
    check("rand_sum_sq", sum_sq_err, m_sq);
    check("rand_max", 64'(max_abs_err), m_max);

    // Zero sample count
    start_run(32'd0);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    check("zero_err", 64'(err_count), 64'd0);
    check("zero_sum_abs", sum_abs_err, 64'd0);
    check("zero_sum_sq", sum_sq_err, 64'd0);
    check("zero_max", 64'(max_abs_err), 64'd0);

    // Saturation on the narrow-accumulator instance
    start_run(32'd2);
    push(16'd12, 16'd0, 17'd0);
    push(16'd12, 16'd0, 17'd0);
    wait_done("sat_done");
    check("sat8_done", 64'(done8), 64'd1);
    check("sat8_busy", 64'(busy8), 64'd0);
    check("sat8_ready", 64'(in_ready8), 64'd0);
    check("sat8_sum_sq", 64'(sq8), 64'hFF);
    check("sat8_flag", 64'(sat8), 64'd1);
    check("sat8_sum_abs", 64'(abs8), 64'h18);
    check("sat8_err", 64'(err8), 64'd2);
    check("sat8_max", 64'(max8), 64'd12);
    check("sat64_sum_sq", sum_sq_err, 64'd288);
    check("sat64_flag", 64'(saturated), 64'd0);
    start_run(32'd0);
    check("sat8_cleared", 64'(sat8), 64'd0);
    check("sat8_sq_cleared", 64'(sq8), 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/approx_add_error_monitor.md
Name: approx_add_error_monitor

Overview:
Sequential sink that consumes result samples from an approximate adder under test and accumulates the error statistics the delay/MSE flow reports. Statistics are error count, sum of absolute error, sum of squared error and max absolute error. Each sample carries both operands and the approximate sum. The block computes the exact sum internally, accumulates over a programmed sample count, then holds results until the next run.

Parameters:
WIDTH, 16, operand width; approximate sum is WIDTH+1 bits
CNT_W, 32, width of sample counter and num_samples
ACC_W, 64, width of sum_abs_err and sum_sq_err accumulators

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin a run; sampled only in IDLE or DONE
num_samples  input  CNT_W  samples per run; captured on accepted start
in_valid  input  1  sample present on in_a/in_b/in_approx
in_ready  output  1  block accepts sample this cycle
in_a  input  WIDTH  operand 1
in_b  input  WIDTH  operand 2
in_approx  input  WIDTH+1  approximate sum from adder under test
busy  output  1  run in progress (RUN or DRAIN)
done  output  1  results valid; held high in DONE
err_count  output  CNT_W  samples with nonzero error
sum_abs_err  output  ACC_W  sum of |exact-approx|
sum_sq_err  output  ACC_W  sum of (exact-approx)^2
max_abs_err  output  WIDTH+1  largest |exact-approx| seen
saturated  output  1  sticky; an accumulator clamped this run

Behaviour:
- Reset (async, any state): state=IDLE; in_ready, busy, done, saturated = 0; all statistic outputs = 0; counters and pipeline valids cleared. Reset mid-run discards the run.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start=1: capture num_samples and clear all statistics and saturated.
  - If captured count = 0, go to DONE (done=1 next cycle, stats 0).
  - Otherwise go to RUN. done drops the cycle after start is accepted.
- RUN: in_ready = 1 while accepted < captured count. A transfer occurs when in_valid & in_ready. in_ready deasserts combinationally once the last sample is accepted. After the last transfer, go to DRAIN.
- start is ignored in RUN/DRAIN. busy = 1 exactly in RUN and DRAIN.
- Pipeline, 2 stages, a new sample accepted every cycle:
  - S1 registers exact = in_a + in_b (WIDTH+1 bits, zero-extended) and abs_err = |exact - in_approx| (WIDTH+1 bits unsigned), plus nz = (abs_err != 0).
  - S2 registers: err_count += nz; sum_abs_err += abs_err; sum_sq_err += abs_err*abs_err (2*WIDTH+2-bit product, zero-extended); max_abs_err = max(max_abs_err, abs_err).
- Statistics visible on outputs are S2 registers. They update 2 cycles after a transfer.
- DRAIN: wait until both pipeline stages are empty (2 cycles after the final transfer), then go to DONE. done rises the cycle the final sample's update is visible.
- Saturation: if sum_abs_err or sum_sq_err would exceed 2^ACC_W-1, clamp that accumulator to all-ones and set saturated=1 (sticky until next accepted start). err_count cannot overflow because it is bounded by num_samples.
- in_valid high with in_ready low: no transfer; the sample must be held by the source. in_valid low in RUN: stall, no timeout.
- DONE holds all outputs stable until an accepted start or reset.

Test Plan:
- Reset mid-run: start with num_samples=10; assert rst after 3 transfers -> all outputs 0, state IDLE, in_ready=0; a new start works normally.
- Exact samples: num_samples=4, each with a=b=0x1234 and approx=0x02468 -> err_count=0, sums=0, max=0, done after final update.
- Mixed error: samples (1,1,approx 3), (0xFFFF,1,approx 0x0FFFF), (5,2,approx 7):
  - errors are 1, 1, 0.
  - Expect err_count=2, sum_abs=2, sum_sq=2, max=1.
- Large error: a=0xFFFF, b=0xFFFF, approx=0 -> abs=0x1FFFE, sq=0x3FFF80004, max=0x1FFFE.
- Backpressure/throughput: in_valid toggled randomly over 100 samples -> exactly 100 transfers, in_ready low after the 100th. Results match a reference model; back-to-back valid yields one transfer per cycle.
- Zero count and saturation: num_samples=0 -> done next cycle with all stats 0. With ACC_W=8 and two samples of abs=12 -> sum_sq clamps to 0xFF, saturated=1.
